// File: rtl/ov7670_capture.sv
// ov7670_capture: samples the OV7670 parallel bus on PCLK, pairs bytes into
// RGB565 pixels and writes them into a linear frame buffer (addr = row*H_OUT + col).
// Optional build macro: CAPTURE_DECIMATE_EN -- the camera streams 640x480 and
// only even columns of even lines are stored.
module ov7670_capture #(
  parameter int H_OUT       = 320,
  parameter int V_OUT       = 240,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic        capturing,
  output logic        overflow
);

  localparam int XW = $clog2(H_OUT + 1);
  localparam int YW = $clog2(V_OUT + 1);
  localparam int SW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [16:0]   H_STEP   = 17'(H_OUT);
  localparam logic [XW-1:0] X_LIM    = XW'(H_OUT);
  localparam logic [YW-1:0] Y_LIM    = YW'(V_OUT);
  localparam logic [SW-1:0] SKIP_LIM = SW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_SETTLE  = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Input register stage plus one extra vsync/href stage for edge detection.
  logic        vsync_in_q, href_in_q;
  logic [7:0]  data_in_q;
  logic        vsync_prev_q, href_prev_q;

  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [XW-1:0] x_out_q, x_out_d;
  logic [YW-1:0] y_out_q, y_out_d;
  logic [16:0]   line_base_q, line_base_d;
  logic          overflow_q, overflow_d;
  logic          wr_en_q, wr_en_d;
  logic [16:0]   wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          frame_done_q, frame_done_d;

`ifdef CAPTURE_DECIMATE_EN
  // Only the parity of the input coordinates matters for 2:1 decimation.
  logic x_par_q, x_par_d;
  logic y_par_q, y_par_d;
`endif

  logic vs_rise, vs_fall, href_fall;
  logic pix_keep, line_keep, pix_fits;

  assign vs_rise   =  vsync_in_q & ~vsync_prev_q;
  assign vs_fall   = ~vsync_in_q &  vsync_prev_q;
  assign href_fall = ~href_in_q  &  href_prev_q;

`ifdef CAPTURE_DECIMATE_EN
  assign pix_keep  = ~x_par_q & ~y_par_q;
  assign line_keep = ~y_par_q;
`else
  assign pix_keep  = 1'b1;
  assign line_keep = 1'b1;
`endif

  assign pix_fits = (x_out_q < X_LIM) && (y_out_q < Y_LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_SETTLE;
    else     state_q <= state_d;
  end

  // Next-state logic: settle, wait for frame start, capture until frame end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SETTLE:  if (skip_cnt_q == SKIP_LIM) state_d = S_WAIT;
      S_WAIT:    if (vs_fall)                state_d = S_CAPTURE;
      S_CAPTURE: if (vs_rise)                state_d = S_WAIT;
      default:                               state_d = S_SETTLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    capturing = (state_q == S_CAPTURE);
  end

  // Datapath: byte pairing, keep/fit decision, line advance and frame end.
  always_comb begin
    skip_cnt_d   = skip_cnt_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    line_base_d  = line_base_q;
    overflow_d   = overflow_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
    x_par_d      = x_par_q;
    y_par_d      = y_par_q;
`endif
    case (state_q)
      S_SETTLE: begin
        if (vs_rise && (skip_cnt_q != SKIP_LIM)) skip_cnt_d = skip_cnt_q + 1'b1;
      end
      S_WAIT: begin
        if (vs_fall) begin
          phase_d     = 1'b0;
          x_out_d     = '0;
          y_out_d     = '0;
          line_base_d = '0;
          overflow_d  = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
          x_par_d     = 1'b0;
          y_par_d     = 1'b0;
`endif
        end
      end
      S_CAPTURE: begin
        // A pixel completing in the frame-end cycle is still written.
        if (href_in_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_in_q;
          end else begin
            if (pix_keep) begin
              if (pix_fits) begin
                wr_en_d   = 1'b1;
                wr_addr_d = line_base_q + 17'(x_out_q);
                wr_data_d = {hi_q, data_in_q};
                x_out_d   = x_out_q + 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
`ifdef CAPTURE_DECIMATE_EN
            x_par_d = ~x_par_q;
`endif
          end
        end
        // Frame end wins over a coincident line end; the partial line is dropped.
        if (vs_rise) begin
          frame_done_d = 1'b1;
        end else if (href_fall) begin
          phase_d = 1'b0;
          x_out_d = '0;
`ifdef CAPTURE_DECIMATE_EN
          x_par_d = 1'b0;
          y_par_d = ~y_par_q;
`endif
          // y_out saturates at V_OUT so line_base never passes H_OUT*V_OUT.
          if (line_keep && (y_out_q < Y_LIM)) begin
            y_out_d     = y_out_q + 1'b1;
            line_base_d = line_base_q + H_STEP;
          end
        end
      end
      default: ;
    endcase
  end

  // Input sampling, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_in_q   <= 1'b0;
      href_in_q    <= 1'b0;
      data_in_q    <= 8'h00;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      skip_cnt_q   <= '0;
      phase_q      <= 1'b0;
      hi_q         <= 8'h00;
      x_out_q      <= '0;
      y_out_q      <= '0;
      line_base_q  <= '0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
      x_par_q      <= 1'b0;
      y_par_q      <= 1'b0;
`endif
    end else begin
      vsync_in_q   <= cam_vsync;
      href_in_q    <= cam_href;
      data_in_q    <= cam_data;
      vsync_prev_q <= vsync_in_q;
      href_prev_q  <= href_in_q;
      skip_cnt_q   <= skip_cnt_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      line_base_q  <= line_base_d;
      overflow_q   <= overflow_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
`ifdef CAPTURE_DECIMATE_EN
      x_par_q      <= x_par_d;
      y_par_q      <= y_par_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: table-driven and randomized frames checked against a
// pixel-level model of the frame buffer contents (small H/V for run time).
`timescale 1ns/1ps
module tb_ov7670_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
`ifdef CAPTURE_DECIMATE_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done, capturing, overflow;

  always #5 clk = ~clk;

  ov7670_capture #(.H_OUT(H), .V_OUT(V), .SKIP_FRAMES(SKIP)) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .capturing  (capturing),
    .overflow   (overflow)
  );

  // Monitor: log every write and every frame_done pulse (with its width).
  logic [32:0] act_log [$];
  int fd_pulses = 0;
  int fd_long   = 0;
  int fd_run    = 0;
  always @(negedge clk) begin
    if (wr_en) act_log.push_back({wr_addr, wr_data});
    if (frame_done) begin
      fd_run = fd_run + 1;
      if (fd_run == 1) fd_pulses = fd_pulses + 1;
      else             fd_long   = fd_long + 1;
    end else begin
      fd_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;
  int rd_idx   = 0;

  // Reference model state.
  logic [32:0] exp_q [$];
  logic [7:0]  line_b [0:63];
  int m_skip, m_y_in, m_y_out;
  bit m_active, m_ovf;

  typedef struct {
    int lines;
    int bytes;
    int exp_writes;
    int exp_last;
    bit exp_ovf;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  // Frame-buffer model of one completed line held in line_b[0..n-1].
  task automatic model_line(input int n);
    int  k;
    bit  keep;
    k = 0;
    if (m_active) begin
      for (int i = 0; i < n / 2; i++) begin
        keep = DECIM ? ((m_y_in % 2 == 0) && (i % 2 == 0)) : 1'b1;
        if (keep) begin
          if (k < H && m_y_out < V)
            exp_q.push_back({17'(m_y_out * H + k), line_b[2*i], line_b[2*i+1]});
          else
            m_ovf = 1'b1;
          k++;
        end
      end
      if (!DECIM || (m_y_in % 2 == 0)) m_y_out++;
      m_y_in++;
    end
  endtask

  task automatic send_line(input int n);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < n; i++) begin
      line_b[i] = 8'($urandom);
      cyc(0, 1, line_b[i]);
    end
    model_line(n);
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    logic [32:0] a, e;
    n = act_log.size() - rd_idx;
    chk({tag, " write_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      a = act_log[rd_idx + i];
      e = exp_q[i];
      chk({tag, " write_addr"}, 64'(a[32:16]), 64'(e[32:16]));
      chk({tag, " write_data"}, 64'(a[15:0]),  64'(e[15:0]));
    end
    $display("frame %s writes=%0d expected=%0d", tag, n, exp_q.size());
    rd_idx = act_log.size();
    exp_q.delete();
  endtask

  // Model consequences of a vsync pulse (settle count, new frame start).
  task automatic model_pulse();
    if (m_skip < SKIP) m_skip++;
    if (m_skip >= SKIP) begin
      m_active = 1'b1;
      m_y_in   = 0;
      m_y_out  = 0;
      m_ovf    = 1'b0;
    end
  endtask

  task automatic end_frame(input string tag);
    int fd0;
    bit was_active;
    fd0 = fd_pulses;
    was_active = m_active;
    repeat (3) cyc(0, 0, 8'h00);
    chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
    repeat (4) cyc(1, 0, 8'h00);
    model_pulse();
    repeat (4) cyc(0, 0, 8'h00);
    chk({tag, " capturing"}, 64'(capturing), 64'(m_active));
    chk({tag, " frame_done_count"}, 64'(fd_pulses - fd0), 64'(was_active ? 1 : 0));
    cmp_writes(tag);
  endtask

  task automatic model_reset();
    m_skip   = 0;
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_y_in   = 0;
    m_y_out  = 0;
    exp_q.delete();
  endtask

  initial begin
    int base, nl, nb, fd0;
    logic [32:0] last;

`ifdef CAPTURE_DECIMATE_EN
    tbl[0] = '{4, 16,  8, 11, 1'b0};
    tbl[1] = '{3, 18, 10, 12, 1'b0};
    tbl[2] = '{2,  5,  1,  0, 1'b0};
    tbl[3] = '{6,  8,  6, 17, 1'b0};
    tbl[4] = '{2,  2,  1,  0, 1'b0};
`else
    tbl[0] = '{4, 16, 32, 31, 1'b0};
    tbl[1] = '{3, 18, 24, 23, 1'b1};
    tbl[2] = '{2,  5,  4,  9, 1'b0};
    tbl[3] = '{6,  8, 16, 27, 1'b1};
    tbl[4] = '{2,  2,  2,  8, 1'b0};
`endif

    model_reset();
    rst = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset wr_en",      64'(wr_en),      64'(0));
    chk("reset wr_addr",    64'(wr_addr),    64'(0));
    chk("reset wr_data",    64'(wr_data),    64'(0));
    chk("reset frame_done", 64'(frame_done), 64'(0));
    chk("reset capturing",  64'(capturing),  64'(0));
    chk("reset overflow",   64'(overflow),   64'(0));
    rst = 1'b0;

    // Two settle frames: nothing may be written.
    for (int f = 0; f < SKIP; f++) begin
      for (int l = 0; l < 3; l++) send_line(8);
      end_frame("settle");
    end

    // Table of whole frames.
    for (int t = 0; t < 5; t++) begin
      base = act_log.size();
      for (int l = 0; l < tbl[t].lines; l++) send_line(tbl[t].bytes);
      repeat (3) cyc(0, 0, 8'h00);
      chk("tbl overflow", 64'(overflow), 64'(tbl[t].exp_ovf));
      chk("tbl writes", 64'(act_log.size() - base), 64'(tbl[t].exp_writes));
      if (act_log.size() > base) begin
        last = act_log[act_log.size() - 1];
        chk("tbl last_addr", 64'(last[32:16]), 64'(tbl[t].exp_last));
      end
      end_frame("table");
    end

    // First line A0 A1 B0 B1 C0 C1: exact write latency and strobe width.
    line_b[0] = 8'hA0; line_b[1] = 8'hA1; line_b[2] = 8'hB0;
    line_b[3] = 8'hB1; line_b[4] = 8'hC0; line_b[5] = 8'hC1;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(0, 1, line_b[0]);
    cyc(0, 1, line_b[1]);
    cyc(0, 1, line_b[2]);
    chk("lat a_early wr_en", 64'(wr_en), 64'(0));
    cyc(0, 1, line_b[3]);
    chk("lat a wr_en",   64'(wr_en),   64'(1));
    chk("lat a wr_addr", 64'(wr_addr), 64'(0));
    chk("lat a wr_data", 64'(wr_data), 64'(16'hA0A1));
    cyc(0, 1, line_b[4]);
    chk("lat strobe_width", 64'(wr_en), 64'(0));
    cyc(0, 1, line_b[5]);
    chk("lat b wr_en", 64'(wr_en), 64'(DECIM ? 0 : 1));
    cyc(0, 0, 8'h00);
    chk("lat gap wr_en", 64'(wr_en), 64'(0));
    cyc(0, 0, 8'h00);
    chk("lat c wr_en",   64'(wr_en),   64'(1));
    chk("lat c wr_addr", 64'(wr_addr), 64'(DECIM ? 1 : 2));
    chk("lat c wr_data", 64'(wr_data), 64'(16'hC0C1));
    model_line(6);
    send_line(4);
    end_frame("latency");

    // vsync rises together with a phase-1 byte in mid-line.
    fd0 = fd_pulses;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 6; i++) line_b[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) cyc(0, 1, line_b[i]);
    cyc(1, 1, line_b[5]);
    cyc(1, 1, 8'h5A);
    repeat (3) cyc(1, 0, 8'h00);
    model_line(6);
    chk("midline capturing", 64'(capturing), 64'(0));
    chk("midline frame_done_count", 64'(fd_pulses - fd0), 64'(1));
    model_pulse();
    repeat (4) cyc(0, 0, 8'h00);
    chk("midline capturing_again", 64'(capturing), 64'(1));
    cmp_writes("midline");

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      nl = $urandom_range(1, 6);
      nb = $urandom_range(1, 20);
      for (int l = 0; l < nl; l++) send_line(nb);
      end_frame("random");
    end

    // Reset in the middle of a frame.
    send_line(4);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cam_href = 1'b0;
    chk("rst wr_en",      64'(wr_en),      64'(0));
    chk("rst wr_addr",    64'(wr_addr),    64'(0));
    chk("rst wr_data",    64'(wr_data),    64'(0));
    chk("rst frame_done", 64'(frame_done), 64'(0));
    chk("rst capturing",  64'(capturing),  64'(0));
    chk("rst overflow",   64'(overflow),   64'(0));
    cmp_writes("pre_reset");
    model_reset();
    for (int f = 0; f < SKIP; f++) begin
      for (int l = 0; l < 2; l++) send_line(10);
      end_frame("resettle");
    end
    for (int l = 0; l < tbl[0].lines; l++) send_line(tbl[0].bytes);
    end_frame("after_reset");

    chk("frame_done width", 64'(fd_long), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side writer for the 320x240 RGB565 frame buffer. It samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) on the camera pixel clock and assembles byte pairs into 16-bit pixels. It writes those pixels into the dual-port frame-buffer RAM at the same linear address map the VGA read side uses: addr = row*320 + col, 17 bits.

## Interface
Parameters:
- H_OUT, 320: stored pixels per line.
- V_OUT, 240: stored lines per frame.
- SKIP_FRAMES, 2: complete frames discarded after reset while the camera registers settle.

Ports:
- clk, in, 1: camera PCLK; the only clock. All inputs are sampled on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- cam_vsync, in, 1: high during vertical blanking.
- cam_href, in, 1: high while line data is valid.
- cam_data, in, 8: pixel byte.
- wr_en, out, 1: one-cycle RAM write strobe.
- wr_addr, out, 17: RAM write address.
- wr_data, out, 16: RGB565 pixel, with the first byte in [15:8].
- frame_done, out, 1: one-cycle pulse at the end of a captured frame.
- capturing, out, 1: high while in S_CAPTURE.
- overflow, out, 1: sticky; set when a pixel is dropped because it falls outside H_OUT x V_OUT.

## Operation
- Input registers: vsync_d, href_d and data_d hold inputs delayed by one cycle.
  - vs_rise = vsync & ~vsync_d.
  - vs_fall = ~vsync & vsync_d.
  - href_fall = ~href & href_d.
- State S_SETTLE:
  - skip_cnt increments on each vs_rise.
  - When skip_cnt == SKIP_FRAMES, go to S_WAIT.
  - If SKIP_FRAMES == 0, go to S_WAIT on the first cycle after reset.
- State S_WAIT: on vs_fall, clear x_in, y_in, x_out, y_out, line_base, byte phase and overflow, then go to S_CAPTURE.
- State S_CAPTURE, while href_d is high:
  - Phase 0: latch the high byte.
  - Phase 1: form the pixel {hi, data_d}.
  - Phase toggles on every href_d-high cycle.
- State S_CAPTURE, on href_fall:
  - Clear phase and x_in/x_out.
  - Increment y_in.
  - Advance y_out and line_base (+= H_OUT) when the line just ended was a kept line.
  - A half pixel (odd byte count) is discarded.
- State S_CAPTURE, on vs_rise: pulse frame_done, go to S_WAIT. This applies even mid-line; the partial line is discarded.
- Keep rule, applied at phase-1 completion:
  - The pixel is kept if the axis filter passes (see Configuration).
  - If kept, x_out < H_OUT and y_out < V_OUT: write wr_addr = line_base + x_out, then increment x_out.
  - If kept but x_out >= H_OUT or y_out >= V_OUT: no write, set overflow.
  - x_in increments on every completed pixel.
- Address arithmetic: line_base and wr_addr are 17-bit; the maximum written address is H_OUT*V_OUT-1 = 76799. No multiplier is used, and addresses never wrap.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, capturing=0, overflow=0, state=S_SETTLE, skip_cnt=0.
  - Reset mid-frame aborts immediately; SKIP_FRAMES are re-skipped.

## Timing
- Write latency: wr_en, wr_addr and wr_data are registered and valid 2 cycles after the phase-1 byte is on cam_data. The input register accounts for 1 cycle and the output register for 1.
- Write rate: at most one write every 2 cycles.
- frame_done: asserted 2 cycles after cam_vsync rises, for exactly 1 cycle.
- capturing: rises 2 cycles after cam_vsync falls in S_WAIT.
- Simultaneous href_fall and vs_rise: the frame end takes priority, and no line advance is observable.
- A write completing in the same cycle as vs_rise is still issued.

## Configuration
- CAPTURE_DECIMATE_EN defined:
  - Camera runs VGA 640x480.
  - Keep only pixels with x_in[0]==0 on lines with y_in[0]==0.
  - y_out/line_base advance only after even lines.
- CAPTURE_DECIMATE_EN undefined:
  - Camera runs QVGA 320x240.
  - Every completed pixel passes the filter, and every line advances y_out.

## Test plan
- Reset with SKIP_FRAMES=2: drive 2 full frames, then a third 640x480 frame (decimate on) with pixel n = 16'h(n). Expect zero writes during frames 1–2. In frame 3, expect exactly 76800 writes with the last addr = 76799, then one frame_done pulse and overflow=0.
- Decimate on, first line, bytes A0 A1 B0 B1 C0 C1: expect a write addr 0 data A0A1, no write for B, then addr 1 data C0C1. Check the 2-cycle latency from the A1 byte.
- Decimate off, 3 lines with 321 pixels each: expect addrs 0..319, 320..639 and 640..959. The 321st pixel of each line is dropped and overflow=1.
- A line with odd byte count 5: expect 2 writes, and the next line starts at base+H_OUT with phase 0.
- vsync rises mid-line, then rst is pulsed mid-frame: expect frame_done=1 for 1 cycle and capturing=0. After rst, all outputs are 0 and no writes occur until SKIP_FRAMES new frames have passed.
